// File: rtl/tube_bcd_feeder.sv
// Feeder for the 4-digit seven-segment tube driver. It passes hex words straight through,
// or converts them to 4-digit BCD by sequential double-dabble with saturation at DEC_MAX.
module tube_bcd_feeder #(
    parameter int BIN_W   = 16,
    parameter int DEC_MAX = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_data,
    input  logic             in_hex,
    output logic [15:0]      value,
    output logic             set,
    output logic             busy,
    output logic             ovf
);

    localparam int                 CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0]   SAT   = BIN_W'(DEC_MAX);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic             ready_q;
    logic             busy_q;
    logic             set_q;
    logic             ovf_q;
    logic [15:0]      value_q;

    logic [15:0]      bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15+BIN_W:0] step_w;
    logic             accept;

    // Double-dabble correction: any digit that will reach 10+ after the shift gets +3 first.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] d);
        return (d > SAT) ? SAT : d;
    endfunction

    assign accept = in_valid & ready_q;

    always_comb begin
        step_w = {bcd_adjust(bcd_q), bin_q} << 1;
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE && accept && !in_hex) begin
            bcd_d = '0;
            bin_d = saturate(in_data);
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            bcd_d = step_w[15+BIN_W:BIN_W];
            bin_d = step_w[BIN_W-1:0];
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Conversion datapath carries no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        bcd_q <= bcd_d;
        bin_q <= bin_d;
        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            set_q   <= 1'b0;
            ovf_q   <= 1'b0;
            value_q <= 16'h0000;
        end else begin
            set_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_hex) begin
                            value_q <= 16'(in_data);
                            set_q   <= 1'b1;
                        end else begin
                            ovf_q   <= (in_data > SAT);
                            state_q <= SHIFT;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    value_q <= bcd_q;
                    set_q   <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign set      = set_q;
    assign ovf      = ovf_q;
    assign value    = value_q;

endmodule

// File: tb/tb_tube_bcd_feeder.sv
// Self-checking bench for tube_bcd_feeder: directed cases plus randomized requests
// checked against a decimal-digit reference model.
module tb_tube_bcd_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_hex = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_ready;
    logic [15:0] value;
    logic        set;
    logic        busy;
    logic        ovf;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model_val = 16'h0000;
    logic        model_ovf = 1'b0;

    tube_bcd_feeder #(.BIN_W(16), .DEC_MAX(9999)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_hex   (in_hex),
        .value    (value),
        .set      (set),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: saturate, then split into decimal digits arithmetically.
    function automatic logic [15:0] ref_bcd(input int d);
        int s;
        s = (d > 9999) ? 9999 : d;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_wait", in_ready, 1);
    endtask

    task automatic send_dec(input logic [15:0] d);
        int   lat, n_busy;
        logic hold_ok, rdy_ok, nib_ok;
        wait_ready();
        in_valid = 1'b1;
        in_hex   = 1'b0;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat     = 0;
        n_busy  = busy ? 1 : 0;
        hold_ok = 1'b1;
        rdy_ok  = 1'b1;
        while (!set && lat < 40) begin
            if (value !== model_val) hold_ok = 1'b0;
            if (in_ready) rdy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (busy) n_busy++;
        end
        model_val = ref_bcd(int'(d));
        model_ovf = (d > 16'd9999);
        nib_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (value[4*i +: 4] > 4'd9) nib_ok = 1'b0;
        end
        check("dec_latency", lat, 17);
        check("dec_busy_cycles", n_busy, 16);
        check("dec_hold", hold_ok, 1);
        check("dec_ready_low", rdy_ok, 1);
        check("dec_value", value, model_val);
        check("dec_ovf", ovf, model_ovf);
        check("dec_nibbles", nib_ok, 1);
        check("dec_ready_at_set", in_ready, 1);
        @(posedge clk); #1;
        check("dec_set_pulse", set, 0);
        check("dec_value_after", value, model_val);
    endtask

    task automatic send_hex(input logic [15:0] d);
        wait_ready();
        in_valid = 1'b1;
        in_hex   = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_val = d;
        check("hex_set", set, 1);
        check("hex_value", value, model_val);
        check("hex_ovf", ovf, model_ovf);
        check("hex_ready", in_ready, 1);
    endtask

    initial begin
        logic        flag;
        int          k;
        logic [15:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("rst_value", value, 16'h0000);
        check("rst_set", set, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_dec(16'd1234);
        check("t1_value", value, 16'h1234);

        send_dec(16'd9999);
        check("t2_9999", value, 16'h9999);
        send_dec(16'd10000);
        check("t2_10000_ovf", ovf, 1);
        send_dec(16'd65535);
        check("t2_65535", value, 16'h9999);

        // Hex pass-through, then a back-to-back hex request on the next cycle.
        send_hex(16'hBEEF);
        in_valid = 1'b1;
        in_hex   = 1'b1;
        in_data  = 16'h0042;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_val = 16'h0042;
        check("t3_b2b_set", set, 1);
        check("t3_b2b_value", value, 16'h0042);
        check("t3_ovf_kept", ovf, 1);

        send_dec(16'd0);
        check("t2_zero", value, 16'h0000);

        // in_valid held high through a conversion: the second word waits for IDLE.
        wait_ready();
        in_valid = 1'b1;
        in_hex   = 1'b0;
        in_data  = 16'd500;
        @(posedge clk); #1;
        in_data = 16'd42;
        flag = 1'b1;
        k = 0;
        while (!set && k < 40) begin
            if (in_ready) flag = 1'b0;
            if (set && value !== 16'h0500) flag = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check("t4_ready_low", flag, 1);
        check("t4_first_value", value, 16'h0500);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_second_taken", busy, 1);
        k = 0;
        while (!set && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("t4_second_value", value, 16'h0042);
        model_val = 16'h0042;
        model_ovf = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a conversion.
        wait_ready();
        in_valid = 1'b1;
        in_hex   = 1'b0;
        in_data  = 16'd7777;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_val = 16'h0000;
        model_ovf = 1'b0;
        check("t5_value", value, 16'h0000);
        check("t5_set", set, 0);
        check("t5_busy", busy, 0);
        check("t5_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (set) flag = 1'b1;
        end
        check("t5_no_strobe", flag, 0);
        check("t5_value_held", value, 16'h0000);

        // Randomized decimal requests with occasional hex requests mixed in.
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_hex(16'($urandom));
            end
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom);
                1:       d = 16'($urandom_range(0, 9999));
                2:       d = 16'($urandom_range(9990, 10010));
                default: d = 16'($urandom_range(0, 99));
            endcase
            send_dec(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
